// File: rtl/stopwatch_ctrl_if.sv
// Counter/display side of the stopwatch controller: live seconds digits in,
// advance/clear/carry pulses and frozen display digits out.
interface stopwatch_ctrl_if;
  logic [2:0] sec_tens;
  logic [3:0] sec_units;
  logic       cnt_en;
  logic       cnt_clr;
  logic       min_carry;
  logic [2:0] disp_tens;
  logic [3:0] disp_units;
  logic [1:0] state;
  logic       running;

  modport master (
    input  sec_tens, sec_units,
    output cnt_en, cnt_clr, min_carry,
    output disp_tens, disp_units,
    output state, running
  );

  modport slave (
    output sec_tens, sec_units,
    input  cnt_en, cnt_clr, min_carry,
    input  disp_tens, disp_units,
    input  state, running
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: debounced start/stop and lap/reset buttons drive a
// four-state FSM, a one-second prescaler and a lap-freezable display copy.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV   = 100_000_000,
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_ss,
  input  logic btn_lr,
  stopwatch_ctrl_if.master sw
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEB_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_e;

  // Bit 0 is start/stop, bit 1 is lap/reset.
  logic [1:0]         sync1_q, sync2_q;
  logic [1:0]         deb_q, deb_d;
  logic [1:0]         deb_dly_q;
  logic [1:0]         press_q, press_d;
  logic [1:0][DW-1:0] deb_cnt_q, deb_cnt_d;

  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          cnt_en_q, cnt_en_d;
  logic          cnt_clr_q, cnt_clr_d;
  logic [2:0]    disp_t_q, disp_t_d;
  logic [3:0]    disp_u_q, disp_u_d;
  logic          run_s;
  logic          ss_s, lr_s;

  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1))
          deb_d[i] = ~deb_q[i];
        else
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
      end
    end
    press_d = deb_q & ~deb_dly_q;
  end

  assign ss_s  = press_q[0];
  assign lr_s  = press_q[1];
  assign run_s = (state_q == RUN) || (state_q == LAP);

  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    cnt_en_d  = 1'b0;
    cnt_clr_d = 1'b0;
    disp_t_d  = sw.sec_tens;
    disp_u_d  = sw.sec_units;
    // Start/stop takes priority; a same-cycle lap/reset is dropped.
    unique case (state_q)
      IDLE:  if (ss_s) state_d = RUN;
      RUN: begin
        if (ss_s)      state_d = PAUSE;
        else if (lr_s) state_d = LAP;
      end
      LAP: begin
        if (ss_s)      state_d = PAUSE;
        else if (lr_s) state_d = RUN;
      end
      PAUSE: begin
        if (ss_s) begin
          state_d = RUN;
        end else if (lr_s) begin
          state_d   = IDLE;
          cnt_clr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (run_s) begin
      if (pre_q == PW'(TICK_DIV - 1)) begin
        pre_d    = '0;
        cnt_en_d = 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
    if (state_d == IDLE) pre_d = '0;
    if (state_q == LAP) begin
      disp_t_d = disp_t_q;
      disp_u_d = disp_u_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      deb_cnt_q <= '0;
      press_q   <= '0;
      state_q   <= IDLE;
      pre_q     <= '0;
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
      disp_t_q  <= '0;
      disp_u_q  <= '0;
    end else begin
      sync1_q   <= {btn_lr, btn_ss};
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      deb_cnt_q <= deb_cnt_d;
      press_q   <= press_d;
      state_q   <= state_d;
      pre_q     <= pre_d;
      cnt_en_q  <= cnt_en_d;
      cnt_clr_q <= cnt_clr_d;
      disp_t_q  <= disp_t_d;
      disp_u_q  <= disp_u_d;
    end
  end

  assign sw.cnt_en     = cnt_en_q;
  assign sw.cnt_clr    = cnt_clr_q;
  assign sw.min_carry  = cnt_en_q && (sw.sec_tens == 3'd5)
                                  && (sw.sec_units == 4'd9);
  assign sw.disp_tens  = disp_t_q;
  assign sw.disp_units = disp_u_q;
  assign sw.state      = state_q;
  assign sw.running    = run_s;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=5, DEB_CYCLES=4.
// Button presses land on the 8th edge after the raw input goes high.
module tb_stopwatch_ctrl;
  localparam int TD = 5;
  localparam int DB = 4;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic btn_ss = 1'b0;
  logic btn_lr = 1'b0;
  int   n_run  = 0;
  int   n_fail = 0;

  stopwatch_ctrl_if sw();

  stopwatch_ctrl #(
    .TICK_DIV  (TD),
    .DEB_CYCLES(DB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .btn_ss(btn_ss),
    .btn_lr(btn_lr),
    .sw    (sw)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic ss, input logic lr);
    btn_ss = ss;
    btn_lr = lr;
    tick(8);
    btn_ss = 1'b0;
    btn_lr = 1'b0;
  endtask

  initial begin
    int cnt;
    bit found;
    sw.sec_tens  = 3'd0;
    sw.sec_units = 4'd0;

    tick(2);
    check("rst_state", sw.state, 0);
    check("rst_running", sw.running, 0);
    check("rst_cnt_en", sw.cnt_en, 0);
    check("rst_cnt_clr", sw.cnt_clr, 0);
    check("rst_min_carry", sw.min_carry, 0);
    check("rst_disp", {sw.disp_tens, sw.disp_units}, 0);
    reset = 1'b0;
    tick(2);

    // Start latency and prescaler cadence
    btn_ss = 1'b1;
    tick(7);
    check("ss_edge7", sw.state, 0);
    tick(1);
    check("ss_edge8", sw.state, 1);
    check("run_running", sw.running, 1);
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (k == 2) btn_ss = 1'b0;
      check($sformatf("cnt_en_k%0d", k), sw.cnt_en, (k % TD) == 0);
    end

    // Minute carry only on the advance with 59 showing
    sw.sec_tens  = 3'd5;
    sw.sec_units = 4'd9;
    for (int k = 13; k <= 16; k++) begin
      tick(1);
      check($sformatf("min_carry_k%0d", k), sw.min_carry, k == 15);
    end

    // Lap capture and release
    sw.sec_tens  = 3'd2;
    sw.sec_units = 4'd3;
    press(1'b0, 1'b1);
    check("lap_state", sw.state, 3);
    check("lap_disp_cap", {sw.disp_tens, sw.disp_units}, {3'd2, 4'd3});
    sw.sec_units = 4'd7;
    tick(3);
    check("lap_disp_hold", {sw.disp_tens, sw.disp_units}, {3'd2, 4'd3});
    check("lap_running", sw.running, 1);
    cnt = 0;
    repeat (5) begin
      tick(1);
      cnt += int'(sw.cnt_en);
    end
    check("lap_counting", cnt, 1);
    press(1'b0, 1'b1);
    check("unlap_state", sw.state, 1);
    check("unlap_disp_edge", {sw.disp_tens, sw.disp_units}, {3'd2, 4'd3});
    sw.sec_tens  = 3'd4;
    sw.sec_units = 4'd1;
    tick(1);
    check("unlap_disp_lag", {sw.disp_tens, sw.disp_units}, {3'd4, 4'd1});
    tick(8);

    // Pause with the prescaler left at 3
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (sw.cnt_en) begin
        found = 1'b1;
        break;
      end
    end
    check("sync_cnt_en", found, 1);
    press(1'b1, 1'b0);
    check("pause_state", sw.state, 2);
    check("pause_running", sw.running, 0);
    cnt = 0;
    repeat (10) begin
      tick(1);
      cnt += int'(sw.cnt_en);
    end
    check("pause_no_cnt_en", cnt, 0);
    press(1'b1, 1'b0);
    check("resume_state", sw.state, 1);
    tick(1);
    check("resume_cnt_en_1", sw.cnt_en, 0);
    tick(1);
    check("resume_cnt_en_2", sw.cnt_en, 1);
    tick(8);
    press(1'b1, 1'b0);
    check("pause2_state", sw.state, 2);
    tick(8);
    press(1'b0, 1'b1);
    check("clr_state", sw.state, 0);
    check("clr_pulse", sw.cnt_clr, 1);
    check("clr_no_cnt_en", sw.cnt_en, 0);
    tick(1);
    check("clr_pulse_end", sw.cnt_clr, 0);
    tick(8);
    press(1'b1, 1'b0);
    check("rerun_state", sw.state, 1);
    for (int k = 1; k <= TD; k++) begin
      tick(1);
      check($sformatf("rerun_cnt_en_k%0d", k), sw.cnt_en, k == TD);
    end
    tick(4);

    // Short glitch, then simultaneous presses
    btn_ss = 1'b1;
    tick(3);
    btn_ss = 1'b0;
    tick(10);
    check("glitch_ignored", sw.state, 1);
    press(1'b1, 1'b1);
    check("both_ss_wins", sw.state, 2);
    tick(1);
    check("both_lr_dropped", sw.state, 2);
    tick(8);

    // Reset in LAP with start/stop held through it
    press(1'b1, 1'b0);
    check("run_again", sw.state, 1);
    tick(8);
    sw.sec_tens  = 3'd5;
    sw.sec_units = 4'd9;
    press(1'b0, 1'b1);
    check("lap_again", sw.state, 3);
    tick(2);
    btn_ss = 1'b1;
    reset  = 1'b1;
    #1;
    check("mid_rst_state", sw.state, 0);
    check("mid_rst_running", sw.running, 0);
    check("mid_rst_cnt_en", sw.cnt_en, 0);
    check("mid_rst_min_carry", sw.min_carry, 0);
    check("mid_rst_disp", {sw.disp_tens, sw.disp_units}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick(1);
    check("post_rst_cnt_en", sw.cnt_en, 0);
    check("post_rst_min_carry", sw.min_carry, 0);
    tick(6);
    check("held_edge7", sw.state, 0);
    tick(1);
    check("held_edge8", sw.state, 1);
    btn_ss = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
